air_draw_point_queue: RTL and testbench

AIR_DRAW_POINT_QUEUE -- requirements
Module: air_draw_point_queue

---
 rtl/air_draw_point_queue.sv | 138 +++++++++++++
 tb/tb_air_draw_point_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/air_draw_point_queue.sv
// air_draw_point_queue
// Register-driven point queue for an air-drawing pipeline. Software stages
// X, Y and colour through register writes, then commits the point via CTRL.
// Points are clamped to the screen and queued in a first-word-fall-through
// FIFO that feeds a framebuffer writer over a valid/ready handshake.
// Optional feature macro: AIR_DRAW_DEDUP_EN drops a commit that matches the
// last accepted entry.
module air_draw_point_queue #(
    parameter int FIFO_DEPTH = 16,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        reg_wr_en,
    input  logic [1:0]  reg_wr_addr,
    input  logic [31:0] reg_wr_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_colour,
    output logic [6:0]  q_count,
    output logic        q_full,
    output logic        q_overflow
);

    localparam int         PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
    localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);

    logic [15:0]      stg_x_reg, stg_y_reg;
    logic [11:0]      stg_col_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [6:0]       count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic [31:0]      mem [FIFO_DEPTH];

    logic        ctrl_wr, commit, flush, pop_eff, push_ok, is_dup, full;
    logic [9:0]  clamp_x, clamp_y;
    logic [31:0] push_entry, head_entry;

    // Only the low 16 bits of a register write carry information.
    logic unused_bits;
    assign unused_bits = &{1'b0, reg_wr_data[31:16]};

    // Decode CTRL: bit1 (flush) dominates bit0 (commit).
    assign ctrl_wr = reg_wr_en && (reg_wr_addr == 2'd3);
    assign commit  = ctrl_wr && reg_wr_data[0] && !reg_wr_data[1];
    assign flush   = ctrl_wr && reg_wr_data[1];

    // Saturate staged coordinates to the last visible pixel.
    assign clamp_x    = (stg_x_reg >= 16'(SCREEN_W)) ? X_MAX : stg_x_reg[9:0];
    assign clamp_y    = (stg_y_reg >= 16'(SCREEN_H)) ? Y_MAX : stg_y_reg[9:0];
    assign push_entry = {clamp_x, clamp_y, stg_col_reg};

    assign full       = (count_reg == 7'(FIFO_DEPTH));
    assign pix_valid  = (count_reg != 7'd0) && !ARESET;
    assign pop_eff    = pix_valid && pix_ready && !flush;
    // A full queue still takes a commit if the head leaves in the same cycle.
    assign push_ok    = commit && !is_dup && (!full || pop_eff);

`ifdef AIR_DRAW_DEDUP_EN
    logic        last_valid_reg;
    logic [31:0] last_entry_reg;

    assign is_dup = last_valid_reg && (last_entry_reg == push_entry);

    // Remember the most recently accepted entry; reset and flush forget it.
    always_ff @(posedge ACLK) begin
        if (ARESET || flush) begin
            last_valid_reg <= 1'b0;
            last_entry_reg <= '0;
        end else if (push_ok) begin
            last_valid_reg <= 1'b1;
            last_entry_reg <= push_entry;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    // Next occupancy and sticky overflow; flush clears both outright.
    always_comb begin
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (flush) begin
            count_next    = 7'd0;
            overflow_next = 1'b0;
        end else begin
            count_next = count_reg + {6'd0, push_ok} - {6'd0, pop_eff};
            if (commit && !is_dup && full && !pop_eff)
                overflow_next = 1'b1;
        end
    end

    // Staging registers, pointers, occupancy and overflow state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stg_x_reg    <= '0;
            stg_y_reg    <= '0;
            stg_col_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (reg_wr_en && reg_wr_addr == 2'd0) stg_x_reg   <= reg_wr_data[15:0];
            if (reg_wr_en && reg_wr_addr == 2'd1) stg_y_reg   <= reg_wr_data[15:0];
            if (reg_wr_en && reg_wr_addr == 2'd2) stg_col_reg <= reg_wr_data[11:0];
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop_eff) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Entry storage; the write is suppressed during reset so nothing lands.
    always_ff @(posedge ACLK) begin
        if (!ARESET && !flush && push_ok)
            mem[wr_ptr_reg] <= push_entry;
    end

    // Head is read combinationally so a fresh entry is visible right away.
    assign head_entry = mem[rd_ptr_reg];
    assign pix_x      = pix_valid ? head_entry[31:22] : 10'd0;
    assign pix_y      = pix_valid ? head_entry[21:12] : 10'd0;
    assign pix_colour = pix_valid ? head_entry[11:0]  : 12'd0;
    assign q_count    = count_reg;
    assign q_full     = full;
    assign q_overflow = overflow_reg;

endmodule

// File: tb/tb_air_draw_point_queue.sv
// Directed testbench for air_draw_point_queue (default depth and screen).
// Expected values are hand-derived; AIR_DRAW_DEDUP_EN changes one expectation.
module tb_air_draw_point_queue;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_colour;
    logic [6:0]  q_count;
    logic        q_full, q_overflow;

    int total = 0;
    int bad   = 0;

    air_draw_point_queue dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_colour  (pix_colour),
        .q_count     (q_count),
        .q_full      (q_full),
        .q_overflow  (q_overflow)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One register write; returns 1ns after the edge that captured it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_wr_en   = 1'b1;
        reg_wr_addr = a;
        reg_wr_data = d;
        @(posedge ACLK);
        #1;
        reg_wr_en   = 1'b0;
        reg_wr_data = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    initial begin
        ARESET      = 1'b1;
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        pix_ready   = 1'b0;

        // Reset, including a commit attempt while reset is held.
        idle(2);
        wr(2'd0, 32'd9);
        wr(2'd3, 32'd1);
        check("rst_valid", pix_valid, 0);
        check("rst_count", q_count, 0);
        check("rst_full", q_full, 0);
        check("rst_ovf", q_overflow, 0);
        check("rst_x", pix_x, 0);
        ARESET = 1'b0;
        idle(1);
        check("rst_wr_ignored", q_count, 0);
        $display("txn reset: count=%0d valid=%0d", q_count, pix_valid);

        // Basic commit into an empty queue.
        wr(2'd0, 32'd5);
        wr(2'd1, 32'd7);
        wr(2'd2, 32'hF00);
        wr(2'd3, 32'd1);
        check("c1_valid", pix_valid, 1);
        check("c1_x", pix_x, 5);
        check("c1_y", pix_y, 7);
        check("c1_col", pix_colour, 32'hF00);
        check("c1_count", q_count, 1);
        $display("txn commit: x=%0d y=%0d col=%0h count=%0d", pix_x, pix_y, pix_colour, q_count);

        // Out-of-range point is clamped; head stays stable with ready low.
        wr(2'd0, 32'd700);
        wr(2'd1, 32'd500);
        wr(2'd3, 32'd1);
        check("c2_count", q_count, 2);
        idle(2);
        check("hold_x", pix_x, 5);
        pix_ready = 1'b1;
        idle(1);
        pix_ready = 1'b0;
        check("clamp_x", pix_x, 639);
        check("clamp_y", pix_y, 479);
        check("pop_count", q_count, 1);
        $display("txn clamp: x=%0d y=%0d count=%0d", pix_x, pix_y, q_count);

        // In-range boundary passes unchanged: X=639, Y=479.
        wr(2'd0, 32'd639);
        wr(2'd1, 32'd479);
        wr(2'd3, 32'd1);
        check("edge_count", q_count, 2);

        // Flush with commit bit also set: flush wins, nothing pushed.
        wr(2'd3, 32'd3);
        check("flush3_count", q_count, 0);
        check("flush3_valid", pix_valid, 0);
        $display("txn flush+commit: count=%0d", q_count);

        // Same point committed twice.
        wr(2'd0, 32'd1);
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd1);
        wr(2'd3, 32'd1);
`ifdef AIR_DRAW_DEDUP_EN
        check("dup_count", q_count, 1);
`else
        check("dup_count", q_count, 2);
`endif
        check("dup_ovf", q_overflow, 0);
        $display("txn repeat commit: count=%0d", q_count);
        wr(2'd3, 32'd2);

        // Seventeen distinct commits into a depth-16 queue.
        for (int i = 0; i < 17; i++) begin
            wr(2'd0, 32'(i));
            wr(2'd3, 32'd1);
        end
        check("of_count", q_count, 16);
        check("of_full", q_full, 1);
        check("of_ovf", q_overflow, 1);
        check("of_head", pix_x, 0);
        $display("txn overflow: count=%0d full=%0d ovf=%0d", q_count, q_full, q_overflow);
        wr(2'd3, 32'd2);
        check("fl_count", q_count, 0);
        check("fl_ovf", q_overflow, 0);
        check("fl_valid", pix_valid, 0);
        $display("txn flush: count=%0d ovf=%0d valid=%0d", q_count, q_overflow, pix_valid);

        // Fill, then commit while popping on a full queue; pointers wrap.
        for (int i = 0; i < 16; i++) begin
            wr(2'd0, 32'(100 + i));
            wr(2'd3, 32'd1);
        end
        check("fill_full", q_full, 1);
        check("fill_ovf", q_overflow, 0);
        wr(2'd0, 32'd200);
        pix_ready = 1'b1;
        wr(2'd3, 32'd1);
        pix_ready = 1'b0;
        check("fp_count", q_count, 16);
        check("fp_ovf", q_overflow, 0);
        check("fp_full", q_full, 1);
        $display("txn full push+pop: count=%0d ovf=%0d", q_count, q_overflow);
        for (int k = 0; k < 15; k++) begin
            check("drain_x", pix_x, 32'(101 + k));
            pix_ready = 1'b1;
            idle(1);
            pix_ready = 1'b0;
        end
        check("pop16_valid", pix_valid, 1);
        check("pop16_x", pix_x, 200);
        pix_ready = 1'b1;
        idle(1);
        pix_ready = 1'b0;
        check("drain_count", q_count, 0);
        check("drain_valid", pix_valid, 0);
        $display("txn drain: 16th x=200 count=%0d", q_count);

        // Reset for one cycle with three entries queued.
        for (int i = 0; i < 3; i++) begin
            wr(2'd0, 32'(10 + i));
            wr(2'd2, 32'h0AB);
            wr(2'd3, 32'd1);
        end
        check("pre_rst_count", q_count, 3);
        ARESET = 1'b1;
        idle(1);
        check("r3_valid", pix_valid, 0);
        check("r3_count", q_count, 0);
        check("r3_x", pix_x, 0);
        check("r3_y", pix_y, 0);
        check("r3_col", pix_colour, 0);
        ARESET = 1'b0;
        idle(1);
        check("r3_after_valid", pix_valid, 0);
        $display("txn reset with entries: count=%0d valid=%0d", q_count, pix_valid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
